// File: rtl/light_sequence_monitor.sv
// Receive-side checker for traffic-light lamp outputs: tracks phase, dwell in ticks, and sticky errors.
// Define LIGHT_MON_ERRCNT_EN to add the saturating err_count output.
module light_sequence_monitor #(
   parameter int unsigned RED_TICKS    = 10,
   parameter int unsigned GREEN_TICKS  = 8,
   parameter int unsigned YELLOW_TICKS = 2,
   parameter int unsigned TOL          = 1,
   parameter int unsigned TW           = 4,
   parameter int unsigned CW           = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          tick,
   input  logic          red,
   input  logic          yellow,
   input  logic          green,
   input  logic          clear_err,
   output logic [1:0]    phase,
   output logic [TW-1:0] dwell,
   output logic          err_code,
   output logic          err_seq,
   output logic          err_time,
   output logic          err_any,
   output logic          cycle_done,
   output logic [CW-1:0] cycle_count
`ifdef LIGHT_MON_ERRCNT_EN
   ,
   output logic [7:0]    err_count
`endif
);

   localparam logic [1:0] ST_INIT   = 2'd0;
   localparam logic [1:0] ST_RED    = 2'd1;
   localparam logic [1:0] ST_GREEN  = 2'd2;
   localparam logic [1:0] ST_YELLOW = 2'd3;
   localparam int unsigned DWELL_MAX = (1 << TW) - 1;

   // in_valid_q keeps the first clk after reset from judging the cleared input register
   logic          in_valid_q;
   logic          tick_q;
   logic [2:0]    lamp_q;
   logic          partial_q;

   logic [1:0]    code_phase;
   logic          code_ok, change, legal;
   logic          ev_code, ev_seq, ev_short, ev_over, ev_time, cycle_ev;
   logic          err_code_nxt, err_seq_nxt, err_time_nxt;
   logic [TW-1:0] dwell_nxt;
   int unsigned   dwell_i, base, limit;

   function automatic int unsigned exp_ticks(input logic [1:0] p);
      case (p)
         ST_RED:    return RED_TICKS;
         ST_GREEN:  return GREEN_TICKS;
         ST_YELLOW: return YELLOW_TICKS;
         default:   return 0;
      endcase
   endfunction

   always_comb begin
      case (lamp_q)
         3'b100:  code_phase = ST_RED;
         3'b001:  code_phase = ST_GREEN;
         3'b010:  code_phase = ST_YELLOW;
         default: code_phase = ST_INIT;
      endcase
      code_ok = in_valid_q && (code_phase != ST_INIT);
      ev_code = in_valid_q && (code_phase == ST_INIT);
      change  = code_ok && (code_phase != phase);
      legal   = (phase == ST_RED    && code_phase == ST_GREEN)  ||
                (phase == ST_GREEN  && code_phase == ST_YELLOW) ||
                (phase == ST_YELLOW && code_phase == ST_RED);
      dwell_i = 32'(dwell);

      ev_seq   = change && (phase != ST_INIT) && !legal;
      ev_short = change && (phase != ST_INIT) && !partial_q &&
                 (dwell_i + TOL < exp_ticks(phase));

      // A tick coinciding with a phase change is the first tick of the new phase
      base    = change ? 32'd0 : dwell_i;
      limit   = exp_ticks(code_phase) + TOL + 1;
      ev_over = code_ok && tick_q && (base < DWELL_MAX) && (base + 1 == limit);
      ev_time = ev_short || ev_over;

      dwell_nxt = dwell;
      if (code_ok)
         dwell_nxt = (tick_q && base < DWELL_MAX) ? TW'(base + 1) : TW'(base);

      cycle_ev = change && (phase == ST_YELLOW) && (code_phase == ST_RED);

      err_code_nxt = ev_code || (err_code && !clear_err);
      err_seq_nxt  = ev_seq  || (err_seq  && !clear_err);
      err_time_nxt = ev_time || (err_time && !clear_err);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_valid_q  <= 1'b0;
         tick_q      <= 1'b0;
         lamp_q      <= '0;
         partial_q   <= 1'b0;
         phase       <= ST_INIT;
         dwell       <= '0;
         err_code    <= 1'b0;
         err_seq     <= 1'b0;
         err_time    <= 1'b0;
         err_any     <= 1'b0;
         cycle_done  <= 1'b0;
         cycle_count <= '0;
      end else begin
         in_valid_q <= 1'b1;
         tick_q     <= tick;
         lamp_q     <= {red, yellow, green};
         if (change) begin
            phase     <= code_phase;
            partial_q <= (phase == ST_INIT);
         end
         dwell       <= dwell_nxt;
         err_code    <= err_code_nxt;
         err_seq     <= err_seq_nxt;
         err_time    <= err_time_nxt;
         err_any     <= err_code_nxt || err_seq_nxt || err_time_nxt;
         cycle_done  <= cycle_ev;
         cycle_count <= cycle_count + {{(CW-1){1'b0}}, cycle_ev};
      end
   end

`ifdef LIGHT_MON_ERRCNT_EN
   logic [1:0] ev_num;
   logic [8:0] ec_sum;

   always_comb begin
      ev_num = 2'(ev_code) + 2'(ev_seq) + 2'(ev_time);
      ec_sum = {1'b0, err_count} + {7'b0, ev_num};
   end

   always_ff @(posedge clk) begin
      if (reset)
         err_count <= '0;
      else
         err_count <= ec_sum[8] ? 8'hFF : ec_sum[7:0];
   end
`endif

endmodule
